pong_input_conditioner: RTL and testbench

PONG_INPUT_CONDITIONER -- requirements
Module: pong_input_conditioner

---
 rtl/pong_pkg.sv | 25 ++
 rtl/pong_debounce.sv | 85 ++++++++
 rtl/pong_input_conditioner.sv | 71 +++++++
 tb/tb_pong_input_conditioner.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pong_pkg.sv
// Shared constants and debounce state encoding for the pong input conditioner.
package pong_pkg;

  localparam int unsigned DebounceCyclesDefault = 250000;  // 10 ms at 25 MHz

  localparam int unsigned NumButtons = 5;
  localparam int unsigned BtnP2Down  = 0;
  localparam int unsigned BtnP2Up    = 1;
  localparam int unsigned BtnP1Down  = 2;
  localparam int unsigned BtnP1Up    = 3;
  localparam int unsigned BtnStart   = 4;

  typedef enum logic [1:0] {
    StableLow  = 2'd0,
    RiseCheck  = 2'd1,
    StableHigh = 2'd2,
    FallCheck  = 2'd3
  } deb_state_e;

  // The accepted level only drops once a fall check completes.
  function automatic logic level_of(deb_state_e state);
    return (state == StableHigh) || (state == FallCheck);
  endfunction

endpackage

// File: rtl/pong_debounce.sv
// One button channel: optional inversion, two-flop synchronizer and debounce FSM.
module pong_debounce
  import pong_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DebounceCyclesDefault,
  parameter bit          ACTIVE_LOW      = 1'b0
) (
  input  logic clock,
  input  logic reset_n,
  input  logic i_raw,
  output logic o_level
);

  localparam int unsigned     CntW    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

  logic            w_raw;
  logic            r_sync1;
  logic            r_sync2;
  deb_state_e      r_state;
  deb_state_e      w_state_d;
  logic [CntW-1:0] r_cnt;
  logic [CntW-1:0] w_cnt_d;

  assign w_raw = i_raw ^ ACTIVE_LOW;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_state <= StableLow;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
      r_state <= w_state_d;
      r_cnt   <= w_cnt_d;
    end
  end

  // Counter clears on every check entry and exit, so it never wraps.
  always_comb begin
    w_state_d = r_state;
    w_cnt_d   = r_cnt;
    unique case (r_state)
      StableLow: begin
        if (r_sync2) begin
          w_state_d = RiseCheck;
          w_cnt_d   = '0;
        end
      end
      RiseCheck: begin
        if (!r_sync2) begin
          w_state_d = StableLow;
          w_cnt_d   = '0;
        end else if (r_cnt == CntLast) begin
          w_state_d = StableHigh;
          w_cnt_d   = '0;
        end else begin
          w_cnt_d = r_cnt + 1'b1;
        end
      end
      StableHigh: begin
        if (!r_sync2) begin
          w_state_d = FallCheck;
          w_cnt_d   = '0;
        end
      end
      FallCheck: begin
        if (r_sync2) begin
          w_state_d = StableHigh;
          w_cnt_d   = '0;
        end else if (r_cnt == CntLast) begin
          w_state_d = StableLow;
          w_cnt_d   = '0;
        end else begin
          w_cnt_d = r_cnt + 1'b1;
        end
      end
    endcase
  end

  assign o_level = level_of(r_state);

endmodule

// File: rtl/pong_input_conditioner.sv
// Debounces the five pong buttons, pulses start once per press, filters paddle conflicts.
module pong_input_conditioner
  import pong_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES   = DebounceCyclesDefault,
  parameter bit          BUTTON_ACTIVE_LOW = 1'b0
) (
  input  logic clock,
  input  logic reset_n,
  input  logic raw_start,
  input  logic raw_p1_up,
  input  logic raw_p1_down,
  input  logic raw_p2_up,
  input  logic raw_p2_down,
  output logic start,
  output logic p1_up,
  output logic p1_down,
  output logic p2_up,
  output logic p2_down
);

  logic [NumButtons-1:0] w_raw;
  logic [NumButtons-1:0] w_level;

  logic r_start_prev;
  logic r_start;
  logic r_p1_up;
  logic r_p1_down;
  logic r_p2_up;
  logic r_p2_down;

  assign w_raw = {raw_start, raw_p1_up, raw_p1_down, raw_p2_up, raw_p2_down};

  for (genvar i = 0; i < NumButtons; i++) begin : g_btn
    pong_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .ACTIVE_LOW     (BUTTON_ACTIVE_LOW)
    ) u_debounce (
      .clock  (clock),
      .reset_n(reset_n),
      .i_raw  (w_raw[i]),
      .o_level(w_level[i])
    );
  end

  // Pressing both directions of one paddle cancels that paddle's movement.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_start_prev <= 1'b0;
      r_start      <= 1'b0;
      r_p1_up      <= 1'b0;
      r_p1_down    <= 1'b0;
      r_p2_up      <= 1'b0;
      r_p2_down    <= 1'b0;
    end else begin
      r_start_prev <= w_level[BtnStart];
      r_start      <= w_level[BtnStart] & ~r_start_prev;
      r_p1_up      <= w_level[BtnP1Up] & ~w_level[BtnP1Down];
      r_p1_down    <= w_level[BtnP1Down] & ~w_level[BtnP1Up];
      r_p2_up      <= w_level[BtnP2Up] & ~w_level[BtnP2Down];
      r_p2_down    <= w_level[BtnP2Down] & ~w_level[BtnP2Up];
    end
  end

  assign start   = r_start;
  assign p1_up   = r_p1_up;
  assign p1_down = r_p1_down;
  assign p2_up   = r_p2_up;
  assign p2_down = r_p2_down;

endmodule

// File: tb/tb_pong_input_conditioner.sv
// Bench for pong_input_conditioner: vector table, corner sequences, random run vs. a window model.
module tb_pong_input_conditioner;

  localparam int unsigned N = 4;

  logic       clock   = 1'b0;
  logic       reset_n = 1'b1;
  logic [4:0] raw     = 5'b0;     // {start, p1_up, p1_down, p2_up, p2_down}
  logic [4:0] al_raw  = 5'b11111; // inputs of the active-low instance
  logic       start, p1_up, p1_down, p2_up, p2_down;
  logic       al_start, al_p1_up, al_p1_down, al_p2_up, al_p2_down;
  logic [4:0] dut_out;
  logic [4:0] al_out;

  always #5 clock = ~clock;

  pong_input_conditioner #(
    .DEBOUNCE_CYCLES  (N),
    .BUTTON_ACTIVE_LOW(1'b0)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .raw_start  (raw[4]),
    .raw_p1_up  (raw[3]),
    .raw_p1_down(raw[2]),
    .raw_p2_up  (raw[1]),
    .raw_p2_down(raw[0]),
    .start      (start),
    .p1_up      (p1_up),
    .p1_down    (p1_down),
    .p2_up      (p2_up),
    .p2_down    (p2_down)
  );

  pong_input_conditioner #(
    .DEBOUNCE_CYCLES  (N),
    .BUTTON_ACTIVE_LOW(1'b1)
  ) dut_al (
    .clock      (clock),
    .reset_n    (reset_n),
    .raw_start  (al_raw[4]),
    .raw_p1_up  (al_raw[3]),
    .raw_p1_down(al_raw[2]),
    .raw_p2_up  (al_raw[1]),
    .raw_p2_down(al_raw[0]),
    .start      (al_start),
    .p1_up      (al_p1_up),
    .p1_down    (al_p1_down),
    .p2_up      (al_p2_up),
    .p2_down    (al_p2_down)
  );

  assign dut_out = {start, p1_up, p1_down, p2_up, p2_down};
  assign al_out  = {al_start, al_p1_up, al_p1_down, al_p2_up, al_p2_down};

  int checks = 0;
  int errors = 0;
  bit al_quiet = 1'b1;

  // Reference model: an accepted level flips once N+1 consecutive
  // synchronized samples disagree with it; samples arrive two edges late.
  logic [4:0] m_d1, m_d2, m_lvl, m_out;
  logic       m_start_prev;
  int         m_run[5];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_d1 = '0;
    m_d2 = '0;
    m_lvl = '0;
    m_out = '0;
    m_start_prev = 1'b0;
    for (int i = 0; i < 5; i++) m_run[i] = 0;
  endtask

  task automatic model_edge();
    logic [4:0] y;
    m_out[4] = m_lvl[4] & ~m_start_prev;
    m_out[3] = m_lvl[3] & ~m_lvl[2];
    m_out[2] = m_lvl[2] & ~m_lvl[3];
    m_out[1] = m_lvl[1] & ~m_lvl[0];
    m_out[0] = m_lvl[0] & ~m_lvl[1];
    m_start_prev = m_lvl[4];
    y = m_d2;
    m_d2 = m_d1;
    m_d1 = raw;
    for (int i = 0; i < 5; i++) begin
      if (y[i] != m_lvl[i]) begin
        m_run[i]++;
        if (m_run[i] == int'(N) + 1) begin
          m_lvl[i] = ~m_lvl[i];
          m_run[i] = 0;
        end
      end else begin
        m_run[i] = 0;
      end
    end
  endtask

  task automatic tick();
    @(posedge clock);
    model_edge();
    #1;
    check("model_start", int'(start), int'(m_out[4]));
    check("model_p1_up", int'(p1_up), int'(m_out[3]));
    check("model_p1_down", int'(p1_down), int'(m_out[2]));
    check("model_p2_up", int'(p2_up), int'(m_out[1]));
    check("model_p2_down", int'(p2_down), int'(m_out[0]));
    if (al_quiet) check("al_quiet", int'(al_out), 0);
  endtask

  typedef struct {
    logic [4:0] in;
    int         hold;
    logic [4:0] exp;
  } vec_t;

  vec_t tbl[8];

  initial begin
    int cnt;
    int first;

    tbl[0] = '{in: 5'b00000, hold: 10, exp: 5'b00000};
    tbl[1] = '{in: 5'b01000, hold: 10, exp: 5'b01000};
    tbl[2] = '{in: 5'b01100, hold: 10, exp: 5'b00000};
    tbl[3] = '{in: 5'b00100, hold: 10, exp: 5'b00100};
    tbl[4] = '{in: 5'b00110, hold: 10, exp: 5'b00110};
    tbl[5] = '{in: 5'b00011, hold: 10, exp: 5'b00000};
    tbl[6] = '{in: 5'b10000, hold: 10, exp: 5'b00000};
    tbl[7] = '{in: 5'b00000, hold: 10, exp: 5'b00000};

    #1 reset_n = 1'b0;
    #2;
    check("reset_outputs", int'(dut_out), 0);
    check("reset_al_outputs", int'(al_out), 0);
    model_reset();
    repeat (3) @(negedge clock);
    reset_n = 1'b1;

    // Table vectors
    for (int v = 0; v < 8; v++) begin
      raw = tbl[v].in;
      repeat (tbl[v].hold) tick();
      check($sformatf("table_%0d", v), int'(dut_out), int'(tbl[v].exp));
    end

    // p1_up latency: 0 through edge k+6, 1 from edge k+7
    raw = 5'b01000;
    for (int j = 0; j < 10; j++) begin
      tick();
      check($sformatf("latency_p1_up_%0d", j), int'(p1_up), (j >= 7) ? 1 : 0);
    end
    raw = 5'b00000;
    repeat (12) tick();

    // 3-cycle glitch on p2_down is ignored; a later hold takes the full latency
    raw = 5'b00001;
    repeat (3) tick();
    raw = 5'b00000;
    cnt = 0;
    for (int j = 0; j < 15; j++) begin
      tick();
      if (p2_down) cnt++;
    end
    check("glitch_p2_down", cnt, 0);
    raw = 5'b00001;
    for (int j = 0; j < 10; j++) begin
      tick();
      if (j == 6 || j == 7) check($sformatf("requal_p2_down_%0d", j), int'(p2_down), (j == 7) ? 1 : 0);
    end
    raw = 5'b00000;
    repeat (12) tick();

    // Start held 50 cycles: exactly one pulse at k+7, none on release
    raw = 5'b10000;
    cnt = 0;
    first = -1;
    for (int j = 0; j < 50; j++) begin
      tick();
      if (start) begin
        cnt++;
        if (first < 0) first = j;
      end
    end
    check("start_pulse_count", cnt, 1);
    check("start_pulse_edge", first, 7);
    raw = 5'b00000;
    cnt = 0;
    for (int j = 0; j < 20; j++) begin
      tick();
      if (start) cnt++;
    end
    check("start_release_pulses", cnt, 0);

    // p1 conflict, then release of down lets up through 7 cycles later
    raw = 5'b01100;
    repeat (12) tick();
    check("conflict_p1", int'({p1_up, p1_down}), 0);
    raw = 5'b01000;
    for (int j = 0; j < 10; j++) begin
      tick();
      check($sformatf("conflict_rel_down_%0d", j), int'(p1_down), 0);
      check($sformatf("conflict_rel_up_%0d", j), int'(p1_up), (j >= 7) ? 1 : 0);
    end
    raw = 5'b00000;
    repeat (12) tick();

    // Reset during p2_up rise check; held buttons re-qualify from scratch
    raw = 5'b01000;
    repeat (12) tick();
    check("pre_reset_p1_up", int'(p1_up), 1);
    raw = 5'b01010;
    repeat (4) tick();
    #2 reset_n = 1'b0;
    #1;
    check("reset_mid_check", int'(dut_out), 0);
    model_reset();
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    for (int j = 0; j < 10; j++) begin
      tick();
      check($sformatf("post_reset_p2_up_%0d", j), int'(p2_up), (j >= 7) ? 1 : 0);
      check($sformatf("post_reset_p1_up_%0d", j), int'(p1_up), (j >= 7) ? 1 : 0);
    end
    raw = 5'b00000;
    repeat (12) tick();

    // Random run against the model
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < 5; i++) begin
        if ($urandom_range(5) == 0) raw[i] = ~raw[i];
      end
      tick();
    end
    raw = 5'b00000;
    repeat (12) tick();

    // Active-low instance: driving raw_start low gives one pulse at k+7
    al_quiet = 1'b0;
    al_raw[4] = 1'b0;
    cnt = 0;
    first = -1;
    for (int j = 0; j < 30; j++) begin
      tick();
      check($sformatf("al_paddles_%0d", j), int'(al_out[3:0]), 0);
      if (al_start) begin
        cnt++;
        if (first < 0) first = j;
      end
    end
    check("al_start_count", cnt, 1);
    check("al_start_edge", first, 7);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
